// File: rtl/one_wire_pkg.sv
// 1-Wire timing constants and slave state encoding, shared by the rx and tx sides.
package one_wire_pkg;

  localparam int T_RSTL_US     = 480;
  localparam int T_RSTL_MIN_US = 450;
  localparam int T_PDH_US      = 15;
  localparam int T_PDL_US      = 490;
  localparam int T_SLOT_US     = 60;
  localparam int T_SAMPLE_US   = 30;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST_HIGH,
    S_PD_WAIT,
    S_PD_LOW,
    S_PD_REL,
    S_BIT_IDLE,
    S_BIT_SAMPLE,
    S_BIT_HIGH
  } ow_state_e;

  function automatic int us2cyc(input int us, input int mhz);
    return us * mhz;
  endfunction

endpackage

// File: rtl/one_wire_sync.sv
// Two-flop bus synchroniser with a registered previous level for
// falling-edge detection. Flops idle high to match the released bus.
module one_wire_sync (
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  output logic level_o,
  output logic fall_o
);

  logic s1_q, s2_q, prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= line_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign level_o = s2_q;
  assign fall_o  = prev_q & ~s2_q;

endmodule

// File: rtl/one_wire_slave_rx.sv
// 1-Wire slave receiver: reset detect, presence pulse, LSB-first byte
// reception. The bus is only ever pulled low during the presence pulse.
module one_wire_slave_rx
  import one_wire_pkg::*;
#(
  parameter int CLK_MHZ     = 100,
  parameter int RSTL_MIN_US = T_RSTL_MIN_US,
  parameter int PD_WAIT_US  = T_PDH_US,
  parameter int PD_LOW_US   = T_PDL_US,
  parameter int SAMPLE_US   = T_SAMPLE_US
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire        one_wire_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       bus_reset,
  output logic       busy
);

  localparam int RSTL_CYC = us2cyc(RSTL_MIN_US, CLK_MHZ);
  localparam int PDH_CYC  = us2cyc(PD_WAIT_US, CLK_MHZ);
  localparam int PDL_CYC  = us2cyc(PD_LOW_US, CLK_MHZ);
  localparam int SMP_CYC  = us2cyc(SAMPLE_US, CLK_MHZ);
  localparam int TMAX =
    (PDL_CYC > PDH_CYC)
      ? ((PDL_CYC > SMP_CYC) ? PDL_CYC : SMP_CYC)
      : ((PDH_CYC > SMP_CYC) ? PDH_CYC : SMP_CYC);
  localparam int LW = $clog2(RSTL_CYC + 2);
  localparam int TW = $clog2(TMAX + 1);

  localparam logic [LW-1:0] RSTL_L = LW'(RSTL_CYC);
  localparam logic [LW-1:0] LSAT   = LW'(RSTL_CYC + 1);
  localparam logic [TW-1:0] PDH_M1 = TW'(PDH_CYC - 1);
  localparam logic [TW-1:0] PDL_M1 = TW'(PDL_CYC - 1);
  localparam logic [TW-1:0] SMP_T  = TW'(SMP_CYC);

  ow_state_e       state_q, state_d;
  logic [LW-1:0]   low_q, low_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [2:0]      bit_q, bit_d;
  logic            done_q, done_d;
  logic [7:0]      sr_q, sr_d;
  logic [7:0]      byte_q, byte_d;
  logic            valid_q, valid_d;
  logic            brst_q, brst_d;
  logic            line, fall, rst_hit;

  one_wire_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .line_i  (one_wire_data),
    .level_o (line),
    .fall_o  (fall)
  );

  // Saturates one past the threshold so a long low fires only once.
  always_comb begin
    low_d = '0;
    if (!line && state_q != S_PD_LOW)
      low_d = (low_q == LSAT) ? low_q : low_q + LW'(1);
  end

  assign rst_hit = (low_q == RSTL_L);

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q + TW'(1);
    bit_d   = bit_q;
    done_d  = done_q;
    sr_d    = sr_q;
    byte_d  = byte_q;
    valid_d = 1'b0;
    brst_d  = 1'b0;
    if (rst_hit) begin
      state_d = S_RST_HIGH;
      brst_d  = 1'b1;
      tmr_d   = '0;
      bit_d   = '0;
      done_d  = 1'b0;
      sr_d    = '0;
    end else begin
      unique case (state_q)
        S_IDLE: tmr_d = '0;
        S_RST_HIGH: begin
          tmr_d = '0;
          if (line) state_d = S_PD_WAIT;
        end
        S_PD_WAIT: begin
          if (tmr_q == PDH_M1) begin
            state_d = S_PD_LOW;
            tmr_d   = '0;
          end
        end
        S_PD_LOW: begin
          if (tmr_q == PDL_M1) begin
            state_d = S_PD_REL;
            tmr_d   = '0;
          end
        end
        S_PD_REL: begin
          tmr_d = '0;
          if (line) state_d = S_BIT_IDLE;
        end
        S_BIT_IDLE: begin
          tmr_d = '0;
          if (fall) state_d = S_BIT_SAMPLE;
        end
        S_BIT_SAMPLE: begin
          if (tmr_q == SMP_T) begin
            sr_d    = {line, sr_q[7:1]};
            state_d = S_BIT_HIGH;
            tmr_d   = '0;
            if (bit_q == 3'd7) done_d = 1'b1;
            else bit_d = bit_q + 3'd1;
          end
        end
        S_BIT_HIGH: begin
          tmr_d = '0;
          if (line) begin
            if (done_q) begin
              byte_d  = sr_q;
              valid_d = 1'b1;
              bit_d   = '0;
              done_d  = 1'b0;
              state_d = S_IDLE;
            end else begin
              state_d = S_BIT_IDLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      low_q   <= '0;
      tmr_q   <= '0;
      bit_q   <= '0;
      done_q  <= 1'b0;
      sr_q    <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      brst_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      low_q   <= low_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      done_q  <= done_d;
      sr_q    <= sr_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      brst_q  <= brst_d;
    end
  end

  assign one_wire_data = (state_q == S_PD_LOW) ? 1'b0 : 1'bz;
  assign rx_byte   = byte_q;
  assign rx_valid  = valid_q;
  assign bus_reset = brst_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_one_wire_slave_rx.sv
// Randomised master-side stimulus for one_wire_slave_rx at CLK_MHZ=1,
// checked every cycle against a transaction-level expectation model.
module tb_one_wire_slave_rx;

  localparam int SYNC_LAT = 2;
  localparam int RSTL     = 450;
  localparam int PDH      = 15;
  localparam int PDL      = 490;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       m_low = 1'b0;
  wire        ow;
  logic [7:0] rx_byte;
  logic       rx_valid, bus_reset, busy;

  pullup (ow);
  assign ow = m_low ? 1'b0 : 1'bz;

  one_wire_slave_rx #(.CLK_MHZ(1)) dut (
    .clk           (clk),
    .rst           (rst),
    .one_wire_data (ow),
    .rx_byte       (rx_byte),
    .rx_valid      (rx_valid),
    .bus_reset     (bus_reset),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  bit         chk_en = 1'b0;
  bit         brst_at[int];
  int         pd_lo = -1, pd_hi = -2;
  bit         exp_pend = 1'b0;
  logic [7:0] exp_val = '0;
  int         exp_dl = 0;
  logic [7:0] last_byte = '0;
  int         busy_exp = -1;
  int         brst_seen = -1;
  int         drv_cnt = 0;
  int         vcnt = 0;
  int         last_rel = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      bit drv;
      drv = (ow === 1'b0) && !m_low;
      if (drv) drv_cnt++;
      if (bus_reset) brst_seen = cyc;
      chk("bus_reset", 32'(bus_reset), 32'(brst_at.exists(cyc)));
      if (!m_low)
        chk("bus_drive", 32'(drv), 32'(cyc >= pd_lo && cyc <= pd_hi));
      if (rx_valid) begin
        vcnt++;
        chk("rx_valid_expected", 32'(exp_pend), 32'd1);
        if (exp_pend) last_byte = exp_val;
        exp_pend = 1'b0;
      end else if (exp_pend && cyc > exp_dl) begin
        chk("rx_valid_timeout", 32'd0, 32'd1);
        exp_pend = 1'b0;
      end
      chk("rx_byte", 32'(rx_byte), 32'(last_byte));
      if (busy_exp >= 0)
        chk("busy", 32'(busy), 32'(busy_exp));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic dut_reset();
    tick(1);
    rst = 1'b1;
    if (pd_hi > cyc) pd_hi = cyc;
    exp_pend = 1'b0;
    tick(1);
    last_byte = '0;
    busy_exp = 0;
    tick(1);
    rst = 1'b0;
  endtask

  // Master reset pulse; returns right after release.
  task automatic master_pulse(input int len, output int c0);
    busy_exp = -1;
    tick(1);
    m_low = 1'b1;
    c0 = cyc;
    brst_at[c0 + SYNC_LAT + RSTL + 1] = 1'b1;
    tick(len);
    m_low = 1'b0;
    pd_lo = cyc + SYNC_LAT + 1 + PDH;
    pd_hi = pd_lo + PDL - 1;
  endtask

  task automatic master_reset(input int len);
    int c0;
    master_pulse(len, c0);
    tick(540);
    busy_exp = 1;
  endtask

  task automatic send_bit(input bit b, input bit rnd);
    int l, h;
    if (rnd) begin
      l = b ? int'($urandom_range(1, 25)) : int'($urandom_range(45, 120));
      h = b ? (62 - l + int'($urandom_range(0, 8))) : int'($urandom_range(4, 10));
    end else begin
      l = b ? 6 : 60;
      h = b ? 54 : 5;
    end
    m_low = 1'b1;
    tick(l);
    m_low = 1'b0;
    last_rel = cyc;
    tick(h);
  endtask

  task automatic send_byte(input logic [7:0] v, input bit rnd);
    logic [7:0] bits;
    bits = v;
    exp_pend = 1'b1;
    exp_val = v;
    exp_dl = 32'h7fffffff;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) busy_exp = -1;
      send_bit(bits[i], rnd);
      if (i == 7) exp_dl = last_rel + 40;
    end
    tick(40);
    busy_exp = 0;
  endtask

  initial begin
    int c0;
    logic [7:0] rb;
    tick(3);
    rst = 1'b0;
    busy_exp = 0;
    chk_en = 1'b1;
    tick(2);
    chk("reset_rx_byte", 32'(rx_byte), 32'h00);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_bus", 32'(ow === 1'b1), 32'd1);

    // Reset detect timing and presence pulse length.
    drv_cnt = 0;
    master_pulse(480, c0);
    tick(540);
    busy_exp = 1;
    chk("brst_latency", 32'(brst_seen - c0), 32'd453);
    chk("presence_len", 32'(drv_cnt), 32'd490);

    send_byte(8'hA5, 1'b0);
    chk("byte_a5", 32'(rx_byte), 32'hA5);

    vcnt = 0;
    master_reset(480);
    send_byte(8'h00, 1'b0);
    chk("byte_00", 32'(rx_byte), 32'h00);
    master_reset(480);
    send_byte(8'hFF, 1'b1);
    chk("byte_ff", 32'(rx_byte), 32'hFF);
    chk("valid_count", 32'(vcnt), 32'd2);

    // Abort after four bits.
    vcnt = 0;
    master_reset(480);
    for (int i = 0; i < 4; i++) send_bit(i[0], 1'b1);
    master_reset(480);
    chk("abort_no_valid", 32'(vcnt), 32'd0);
    chk("abort_hold", 32'(rx_byte), 32'hFF);
    send_byte(8'h3C, 1'b1);
    chk("byte_3c", 32'(rx_byte), 32'h3C);

    // Short lows with no reset: ignored.
    vcnt = 0;
    busy_exp = 0;
    for (int i = 0; i < 20; i++) begin
      m_low = 1'b1;
      tick(10);
      m_low = 1'b0;
      tick(20);
    end
    chk("glitch_no_valid", 32'(vcnt), 32'd0);

    for (int n = 0; n < 6; n++) begin
      master_reset(int'($urandom_range(460, 520)));
      rb = 8'($urandom);
      send_byte(rb, 1'b1);
    end

    // rst in the middle of the presence pulse.
    master_pulse(480, c0);
    tick(200);
    chk("pd_active", 32'(ow === 1'b0), 32'd1);
    dut_reset();
    tick(3);
    chk("pd_rst_bus", 32'(ow === 1'b1), 32'd1);
    chk("pd_rst_byte", 32'(rx_byte), 32'h00);
    chk("pd_rst_busy", 32'(busy), 32'd0);
    tick(20);

    chk("nothing_pending", 32'(exp_pend), 32'd0);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/one_wire_slave_rx.md
ONE_WIRE_SLAVE_RX -- requirements
Module: one_wire_slave_rx

Interface
REQ-001 Parameter CLK_MHZ, 100, system clock frequency in MHz; every timing below in cycles = microseconds x CLK_MHZ.
REQ-002 Parameter RSTL_MIN_US, 450, minimum bus-low time recognised as a master reset pulse.
REQ-003 Parameter PD_WAIT_US, 15, delay from reset-pulse release to presence-pulse start.
REQ-004 Parameter PD_LOW_US, 490, presence-pulse low duration; covers the master's sample point 495 us after release.
REQ-005 Parameter SAMPLE_US, 30, delay from bit-slot falling edge to bit sample.
REQ-006 clk  input  1  system clock; single clock domain.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 one_wire_data  inout  1  open-drain bus; driven 0 or released to 'z'.
REQ-009 rx_byte  output  8  last received byte, LSB received first.
REQ-010 rx_valid  output  1  one-cycle pulse; rx_byte is updated in the same cycle.
REQ-011 bus_reset  output  1  one-cycle pulse when a reset pulse is recognised.
REQ-012 busy  output  1  high in every state except S_IDLE.

Function
REQ-013 The bus input SHALL pass through a 2-flop synchroniser; all decisions use the synchronised level (2-cycle latency).
REQ-014 A low counter SHALL increment while the synchronised line is low and state != S_PD_LOW, and clear otherwise.
REQ-015 When the low counter reaches RSTL_MIN_US x CLK_MHZ, the block SHALL pulse bus_reset, clear the bit count, and enter S_RST_HIGH, whatever the current state.
REQ-016 A reset recognised mid-byte SHALL abort the byte; rx_valid does not pulse and rx_byte holds its old value.
REQ-017 S_IDLE: the block ignores short low pulses and leaves only via REQ-015.
REQ-018 S_RST_HIGH: wait for the synchronised line high, then go to S_PD_WAIT.
REQ-019 S_PD_WAIT: after PD_WAIT_US x CLK_MHZ cycles, go to S_PD_LOW.
REQ-020 S_PD_LOW: drive the bus low for PD_LOW_US x CLK_MHZ cycles, then release and go to S_PD_REL.
REQ-021 S_PD_REL: wait for the synchronised line high, then go to S_BIT_IDLE.
REQ-022 S_BIT_IDLE: on a synchronised falling edge, go to S_BIT_SAMPLE with the counter cleared.
REQ-023 S_BIT_SAMPLE: at count SAMPLE_US x CLK_MHZ, shift the synchronised level into the shift register MSB (right shift, so the byte assembles LSB-first), then go to S_BIT_HIGH.
REQ-024 S_BIT_HIGH: wait for the line high; if 8 bits have been taken, load rx_byte, pulse rx_valid, and go to S_IDLE; otherwise go to S_BIT_IDLE.
REQ-025 The bit counter SHALL be 3 bits plus a done flag; no wrap into a 9th bit.
REQ-026 A low ending before the sample point (glitch shorter than SAMPLE_US) SHALL still sample high, i.e. logic 1.
REQ-027 The block SHALL drive the bus only in S_PD_LOW; otherwise the bus is released.

Reset
REQ-028 On rst: state S_IDLE, bus released, rx_byte=8'h00, rx_valid=0, bus_reset=0, busy=0, all counters and the shift register cleared, synchroniser flops set to 1.
REQ-029 rst asserted mid-presence SHALL release the bus on the next clock edge.

Structure
REQ-030 Timing constants (T_RSTL, T_PDH, T_PDL, T_SLOT, sample point) and the state encoding SHALL live in a shared package one_wire_pkg, used by the transmitter too.
REQ-031 The synchroniser and falling-edge detector SHALL be a sub-module one_wire_sync (2-flop sync plus a registered-previous edge output).

Verification (bench CLK_MHZ=1)
REQ-032 Master drives low 480 cycles, releases -> bus_reset pulses about 452 cycles after the falling edge; bus is driven low from release+15 for 490 cycles.
REQ-033 Reset, then byte 8'hA5 with 1-bits at 6 cycles low and 0-bits at 60 cycles low in 60-cycle slots -> one rx_valid pulse with rx_byte=8'hA5.
REQ-034 Byte 8'h00 followed by a second reset and byte 8'hFF -> rx_valid twice, with values 8'h00 then 8'hFF.
REQ-035 Reset, 4 bits, then a 480-cycle low -> bus_reset pulses, no rx_valid, and the next full byte 8'h3C is received correctly.
REQ-036 10-cycle low pulses with no preceding reset -> no rx_valid, bus never driven, busy=0.
REQ-037 rst during S_PD_LOW -> bus released the next cycle, all outputs at reset values.
